keypad_pin_entry: RTL and testbench

Upstream PIN-entry front end for the intruder-alarm controller. Collects digit key events from the keypad scanner, checks the entered PIN against a fixed code, and drives the 4-bit command bus that the alarm FSM samples on its ENA tick. Arm and disarm commands are issued only for a correct PIN. Repeated wrong entries trigger a timed lockout.

---
 rtl/keypad_pin_entry.sv | 199 +++++++++++++++++++
 tb/tb_keypad_pin_entry.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_pin_entry.sv
// keypad_pin_entry: PIN-entry front end for the intruder-alarm controller.
// Buffers digit key events, checks them against a fixed PIN on ARM/DISARM,
// issues a one-ENA-period command on the keypad bus for a correct PIN, and
// locks the keypad out for a number of ENA ticks after repeated failures.
module keypad_pin_entry #(
  parameter int                      PIN_DIGITS    = 4,
  parameter logic [4*PIN_DIGITS-1:0] PIN           = 16'h1234,
  parameter int                      MAX_FAILS     = 3,
  parameter int                      LOCKOUT_TICKS = 200,
  parameter int                      TIMEOUT_TICKS = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ENA,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] keypad,
  output logic [2:0] digit_count,
  output logic       bad_pin,
  output logic       locked
);

  localparam logic [2:0] LP_DIGITS    = 3'(PIN_DIGITS);
  localparam logic [2:0] LP_MAX_FAILS = 3'(MAX_FAILS);
  localparam logic [7:0] LP_LOCK      = 8'(LOCKOUT_TICKS);
  localparam logic [7:0] LP_TMO       = 8'(TIMEOUT_TICKS);

  localparam logic [3:0] KEY_ARM    = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hC;
  localparam logic [3:0] KEY_DISARM = 4'hD;
  localparam logic [3:0] CMD_ARM    = 4'b0011;
  localparam logic [3:0] CMD_DISARM = 4'b1100;
  localparam logic [3:0] CMD_NONE   = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t                  r_state;
  logic [4*PIN_DIGITS-1:0] r_buf;
  logic [2:0]              r_cnt;
  logic [2:0]              r_fails;
  logic [7:0]              r_lock_cnt;
  logic [7:0]              r_tmo_cnt;
  logic [3:0]              r_keypad;
  logic                    r_bad;
  logic                    r_locked;

  state_t                  w_state_nxt;
  logic [4*PIN_DIGITS-1:0] w_buf_nxt;
  logic [2:0]              w_cnt_nxt;
  logic [2:0]              w_fails_nxt;
  logic [7:0]              w_lock_nxt;
  logic [7:0]              w_tmo_nxt;
  logic [3:0]              w_keypad_nxt;
  logic                    w_bad_nxt;
  logic                    w_locked_nxt;

  // Key decoding and helpers shared by the next-state logic.
  logic                    w_is_digit;
  logic                    w_is_cmd;
  logic                    w_match;
  logic [2:0]              w_fails_inc;
  logic [4*PIN_DIGITS+3:0] w_buf_ext;
  logic [4*PIN_DIGITS-1:0] w_buf_shift;

  assign w_is_digit  = (key_code <= 4'd9);
  assign w_is_cmd    = (key_code == KEY_ARM) || (key_code == KEY_DISARM);
  assign w_match     = (r_cnt == LP_DIGITS) && (r_buf == PIN);
  // Saturate so the counter can never wrap past MAX_FAILS.
  assign w_fails_inc = (r_fails >= LP_MAX_FAILS) ? LP_MAX_FAILS : (r_fails + 3'd1);
  // Newest digit goes into the low nibble; the oldest falls off the top.
  assign w_buf_ext   = {r_buf, key_code};
  assign w_buf_shift = w_buf_ext[4*PIN_DIGITS-1:0];

  // Next-state and next-output logic; key events take priority over ENA.
  always_comb begin
    w_state_nxt  = r_state;
    w_buf_nxt    = r_buf;
    w_cnt_nxt    = r_cnt;
    w_fails_nxt  = r_fails;
    w_lock_nxt   = r_lock_cnt;
    w_tmo_nxt    = r_tmo_cnt;
    w_keypad_nxt = r_keypad;
    w_bad_nxt    = 1'b0;
    w_locked_nxt = r_locked;
    case (r_state)
      ST_IDLE, ST_ENTRY: begin
        if (key_valid && w_is_digit) begin
          if (r_cnt < LP_DIGITS) begin
            w_buf_nxt   = w_buf_shift;
            w_cnt_nxt   = r_cnt + 3'd1;
            w_state_nxt = ST_ENTRY;
          end else begin
            // Buffer full: the digit is dropped, entry stays as it was.
            w_buf_nxt   = r_buf;
            w_cnt_nxt   = r_cnt;
          end
          w_tmo_nxt = LP_TMO;
        end else if (key_valid && (key_code == KEY_CLEAR)) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = ST_IDLE;
        end else if (key_valid && w_is_cmd) begin
          w_buf_nxt = '0;
          w_cnt_nxt = 3'd0;
          if (w_match) begin
            w_keypad_nxt = (key_code == KEY_ARM) ? CMD_ARM : CMD_DISARM;
            w_fails_nxt  = 3'd0;
            w_state_nxt  = ST_ISSUE;
          end else begin
            w_bad_nxt   = 1'b1;
            w_fails_nxt = w_fails_inc;
            if (w_fails_inc == LP_MAX_FAILS) begin
              w_state_nxt  = ST_LOCKOUT;
              w_lock_nxt   = LP_LOCK;
              w_locked_nxt = 1'b1;
            end else begin
              w_state_nxt  = ST_IDLE;
            end
          end
        end else if (ENA && (r_state == ST_ENTRY)) begin
          // Ignored codes fall through here, so they never reload the timeout.
          if (r_tmo_cnt <= 8'd1) begin
            w_tmo_nxt   = 8'd0;
            w_buf_nxt   = '0;
            w_cnt_nxt   = 3'd0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_tmo_nxt   = r_tmo_cnt - 8'd1;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_ISSUE: begin
        // Hold the command until the alarm FSM's next ENA sample.
        if (ENA) begin
          w_keypad_nxt = CMD_NONE;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_keypad_nxt = r_keypad;
        end
      end
      ST_LOCKOUT: begin
        if (ENA) begin
          if (r_lock_cnt <= 8'd1) begin
            w_lock_nxt   = 8'd0;
            w_locked_nxt = 1'b0;
            w_fails_nxt  = 3'd0;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_lock_nxt   = r_lock_cnt - 8'd1;
          end
        end else begin
          w_lock_nxt = r_lock_cnt;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_keypad_nxt = CMD_NONE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_buf      <= '0;
      r_cnt      <= 3'd0;
      r_fails    <= 3'd0;
      r_lock_cnt <= 8'd0;
      r_tmo_cnt  <= 8'd0;
      r_keypad   <= CMD_NONE;
      r_bad      <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_buf      <= w_buf_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fails    <= w_fails_nxt;
      r_lock_cnt <= w_lock_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
      r_keypad   <= w_keypad_nxt;
      r_bad      <= w_bad_nxt;
      r_locked   <= w_locked_nxt;
    end
  end

  assign keypad      = r_keypad;
  assign digit_count = r_cnt;
  assign bad_pin     = r_bad;
  assign locked      = r_locked;

endmodule

// File: tb/tb_keypad_pin_entry.sv
// Self-checking bench for keypad_pin_entry: directed scenarios followed by
// randomized key/ENA traffic, every cycle compared against a behavioural model.
module tb_keypad_pin_entry;

  localparam int T_TMO   = 6;
  localparam int T_LOCK  = 5;
  localparam int T_FAILS = 3;
  localparam int T_PIN   = 'h1234;

  logic       clk = 1'b0;
  logic       reset;
  logic       ENA;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] keypad;
  logic [2:0] digit_count;
  logic       bad_pin;
  logic       locked;

  keypad_pin_entry #(
    .PIN_DIGITS   (4),
    .PIN          (16'h1234),
    .MAX_FAILS    (T_FAILS),
    .LOCKOUT_TICKS(T_LOCK),
    .TIMEOUT_TICKS(T_TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ENA        (ENA),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .keypad     (keypad),
    .digit_count(digit_count),
    .bad_pin    (bad_pin),
    .locked     (locked)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit rnd_ena   = 1'b0;
  bit force_ena = 1'b0;

  // Behavioural model: entered digits, pending command, remaining ticks.
  int q[$];
  int m_cmd      = 0;   // nonzero while a command is being presented
  int m_lock     = 0;   // ENA ticks of lockout remaining, 0 = not locked
  int m_fails    = 0;
  int m_tmo      = 0;
  int m_bad      = 0;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step(input bit kv, input int kc, input bit e, input bit rst);
    int v;
    m_bad = 0;
    if (rst) begin
      q.delete(); m_cmd = 0; m_lock = 0; m_fails = 0; m_tmo = 0;
    end else if (m_cmd != 0) begin
      if (e) m_cmd = 0;
    end else if (m_lock > 0) begin
      if (e) begin
        m_lock--;
        if (m_lock == 0) m_fails = 0;
      end
    end else if (kv && kc <= 9) begin
      if (q.size() < 4) q.push_back(kc);
      m_tmo = T_TMO;
    end else if (kv && kc == 'hC) begin
      q.delete();
    end else if (kv && (kc == 'hA || kc == 'hD)) begin
      v = 0;
      foreach (q[i]) v = v * 16 + q[i];
      if (q.size() == 4 && v == T_PIN) begin
        m_cmd   = (kc == 'hA) ? 'b0011 : 'b1100;
        m_fails = 0;
      end else begin
        m_bad = 1;
        if (m_fails < T_FAILS) m_fails++;
        if (m_fails == T_FAILS) m_lock = T_LOCK;
      end
      q.delete();
    end else if (e && q.size() > 0) begin
      m_tmo--;
      if (m_tmo == 0) q.delete();
    end
  endtask

  task automatic tick(input bit kv, input logic [3:0] kc, input bit rst);
    bit e;
    if (force_ena) e = 1'b1;
    else if (rnd_ena) e = ($urandom_range(0, 3) == 0);
    else e = ((cyc % 4) == 3);
    reset = rst; key_valid = kv; key_code = kc; ENA = e;
    @(posedge clk);
    model_step(kv, int'(kc), e, rst);
    cyc++;
    #1;
    check_val("keypad",      8'(keypad),      8'(m_cmd));
    check_val("digit_count", 8'(digit_count), 8'(q.size()));
    check_val("bad_pin",     8'(bad_pin),     8'(m_bad));
    check_val("locked",      8'(locked),      8'(m_lock > 0));
    reset = 1'b0; key_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] kc);
    tick(1'b1, kc, 1'b0);
    tick(1'b0, 4'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 4'h0, 1'b0);
  endtask

  task automatic enter_pin(input int v);
    for (int i = 3; i >= 0; i--) press(4'((v >> (4 * i)) & 'hF));
  endtask

  initial begin
    reset = 1'b1; ENA = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    tick(1'b0, 4'h0, 1'b1);
    tick(1'b0, 4'h0, 1'b1);

    // Correct PIN then ARM; command held until the next ENA edge.
    enter_pin('h1234); press(4'hA); idle(8);
    // Wrong PIN, then correct PIN with DISARM.
    enter_pin('h1235); press(4'hD); idle(2);
    enter_pin('h1234); press(4'hD); idle(8);
    // Three failures -> lockout; keys during lockout ignored; then arm.
    press(4'h9); press(4'hA);
    press(4'h9); press(4'hA);
    press(4'hA);
    enter_pin('h1234); press(4'hA);
    idle(24);
    enter_pin('h1234); press(4'hA); idle(8);
    // Inter-key timeout.
    press(4'h1); press(4'h2); idle(30);
    enter_pin('h1234); press(4'hA); idle(8);
    // Extra digit dropped; CLEAR.
    enter_pin('h1234); press(4'h9); press(4'hA); idle(8);
    press(4'h1); press(4'h2); press(4'hC); idle(2);
    // Ignored codes.
    press(4'h1); press(4'hB); press(4'hE); press(4'hF); idle(2);
    // Reset while the command is held, before any ENA edge.
    idle(4 - (cyc % 4));
    enter_pin('h1234);
    tick(1'b1, 4'hA, 1'b0);
    tick(1'b0, 4'h0, 1'b1);
    idle(3);
    // Key coincident with ENA reloads the timeout.
    press(4'h1);
    force_ena = 1'b1;
    tick(1'b1, 4'h2, 1'b0);
    tick(1'b0, 4'h0, 1'b0);
    tick(1'b1, 4'h3, 1'b0);
    idle(T_TMO + 2);
    force_ena = 1'b0;
    idle(4);

    // Randomized traffic.
    rnd_ena = 1'b1;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          enter_pin('h1234);
          press($urandom_range(0, 1) ? 4'hA : 4'hD);
        end
        4, 5: begin
          enter_pin(int'($urandom_range(0, 'h9999)) & 'h7777);
          press(4'hA);
        end
        6: press(4'($urandom_range(0, 15)));
        7: idle($urandom_range(0, 10));
        8: tick(1'b0, 4'h0, 1'b1);
        default: press(4'hC);
      endcase
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
